// File: rtl/dmem_lsu.sv
// Requester-side load/store unit for a word-only, combinational-read data memory.
// Handles byte/half/word loads with extension and sub-word stores by read-modify-write.
module dmem_lsu #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_a,
    output logic [DATA_W-1:0] dm_wd,
    input  logic [DATA_W-1:0] dm_rd
);

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW, S_WR, S_RESP} state_t;

    state_t            state_q, state_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic              uns_q, uns_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              resp_valid_d, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_d, dm_wd_d;
    logic [ADDR_W-1:0] dm_a_d, map_addr;
    logic              acc_err;
    logic [4:0]        sh_amt;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [DATA_W-1:0] load_ext, merged;

    assign req_ready = (state_q == S_IDLE);
    // Reset during WR must kill the negedge write in the same cycle.
    assign dm_we     = (state_q == S_WR) & rst_n;

    assign map_addr = WORD_ADDR ? {2'b00, req_addr[ADDR_W-1:2]} : req_addr;
    assign acc_err  = (req_size == 2'b11)
                    | ((req_size == SZ_H) & req_addr[0])
                    | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));

    // Lane extraction with sign/zero extension for loads.
    always_comb begin
        sh_amt  = {off_q, 3'b000};
        rd_byte = dm_rd[sh_amt +: 8];
        rd_half = off_q[1] ? dm_rd[31:16] : dm_rd[15:0];
        case (size_q)
            SZ_B:    load_ext = {{(DATA_W-8){~uns_q & rd_byte[7]}}, rd_byte};
            SZ_H:    load_ext = {{(DATA_W-16){~uns_q & rd_half[15]}}, rd_half};
            default: load_ext = dm_rd;
        endcase
    end

    // Replace only the addressed lane of the word read back from memory.
    always_comb begin
        merged = dm_rd;
        if (size_q == SZ_B) begin
            merged[sh_amt +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        off_d        = off_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = '0;
        dm_a_d       = dm_a;
        dm_wd_d      = dm_wd;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    size_d  = req_size;
                    off_d   = req_addr[1:0];
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata[15:0];
                    if (acc_err) begin
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        dm_a_d = map_addr;
                        if (!req_we) begin
                            state_d = S_RD;
                        end else if (req_size == SZ_W) begin
                            state_d = S_WR;
                            dm_wd_d = req_wdata;
                        end else begin
                            state_d = S_RMW;
                        end
                    end
                end
            end
            S_RD: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_ext;
            end
            S_RMW: begin
                state_d = S_WR;
                dm_wd_d = merged;
            end
            S_WR: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            size_q     <= 2'b00;
            off_q      <= 2'b00;
            uns_q      <= 1'b0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            dm_a       <= '0;
            dm_wd      <= '0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            off_q      <= off_d;
            uns_q      <= uns_d;
            wdata_q    <= wdata_d;
            resp_valid <= resp_valid_d;
            resp_err   <= resp_err_d;
            resp_rdata <= resp_rdata_d;
            dm_a       <= dm_a_d;
            dm_wd      <= dm_wd_d;
        end
    end

endmodule
